// File: rtl/shift_pipe_stage.sv
// -----------------------------------------------------------------------------
// shift_pipe_stage
//
// Two-stage pipelined shift unit. Stage 1 registers the operand, opcode and
// shift amount. Stage 2 registers the shifted result together with a zero
// flag. Valid/ready handshakes on both sides; one word per cycle when the
// consumer does not stall.
//
// Parameters:
//   WIDTH  data width of operand and result words
//   AMT_W  width of the shift-amount field (amounts 0 .. 2**AMT_W-1)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   upstream word present
//   in_ready   stage can accept a word this cycle
//   in_data    operand
//   in_op      00 logical left, 01 logical right, 10 arithmetic left,
//              11 arithmetic right
//   in_amt     shift amount
//   out_valid  result present
//   out_ready  consumer accepts this cycle
//   out_data   shifted result
//   out_zero   out_data == 0, registered alongside out_data
//
// Optional feature (macro SHIFT_PIPE_STATS_EN):
//   stat_count [15:0]  words delivered (out_valid && out_ready), wraps
//   stat_stall [15:0]  cycles with out_valid && !out_ready, saturates
//
// Handshake: a word moves across an interface on a rising clk edge where
// valid && ready are both high on that interface. A producer holds its word
// stable until it is taken; in_ready never looks at in_valid.
// -----------------------------------------------------------------------------
module shift_pipe_stage #(
    parameter int WIDTH = 9,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
`ifdef SHIFT_PIPE_STATS_EN
    ,
    output logic [15:0]      stat_count,
    output logic [15:0]      stat_stall
`endif
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SLA = 2'b10,
        OP_SRA = 2'b11
    } shift_op_e;

    // Stage 1 registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    shift_op_e        s1_op;
    logic [AMT_W-1:0] s1_amt;

    // Stage 2 may load when it is empty or its word leaves this cycle.
    logic s2_can_load;
    assign s2_can_load = !out_valid || out_ready;

    // Held low during reset so nothing is taken while the pipe is cleared.
    assign in_ready = !rst && (!s1_valid || s2_can_load);

    // -------------------------------------------------------------------------
    // Shift datapath, operating on the stage 1 word
    // -------------------------------------------------------------------------
    logic                    amt_big;
    logic [WIDTH-1:0]        sign_fill;
    logic signed [WIDTH-1:0] sra_val;
    logic [WIDTH-1:0]        shift_result;
    logic                    shift_zero;

    // Kept as a standalone signed expression: inside a ternary with an
    // unsigned operand the >>> would silently degrade to a logical shift.
    assign sra_val = $signed(s1_data) >>> s1_amt;

    always_comb begin
        amt_big      = (32'(s1_amt) >= 32'(WIDTH));
        sign_fill    = {WIDTH{s1_data[WIDTH-1]}};
        shift_result = s1_data;
        case (s1_op)
            OP_SLL, OP_SLA: begin
                if (amt_big) shift_result = '0;
                else         shift_result = s1_data << s1_amt;
            end
            OP_SRL: begin
                if (amt_big) shift_result = '0;
                else         shift_result = s1_data >> s1_amt;
            end
            OP_SRA: begin
                if (amt_big) shift_result = sign_fill;
                else         shift_result = sra_val;
            end
            default: shift_result = s1_data;
        endcase
        shift_zero = (shift_result == '0);
    end

    // -------------------------------------------------------------------------
    // Stage 1: capture operand when the stage accepts
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_op    <= OP_SLL;
            s1_amt   <= '0;
        end else if (in_ready) begin
            // Either empty or draining into stage 2 this edge.
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_op   <= shift_op_e'(in_op);
                s1_amt  <= in_amt;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: registered result; holds while the consumer stalls
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
        end else if (s2_can_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= shift_result;
                out_zero <= shift_zero;
            end
        end
    end

`ifdef SHIFT_PIPE_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_count <= '0;
            stat_stall <= '0;
        end else begin
            if (out_valid && out_ready) begin
                stat_count <= stat_count + 16'd1;   // wraps naturally
            end
            if (out_valid && !out_ready && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_pipe_stage.sv
module tb_shift_pipe_stage;

    localparam int W   = 9;
    localparam int AW  = 4;
    localparam int MOD = 2 ** W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_op;
    logic [AW-1:0] in_amt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
`ifdef SHIFT_PIPE_STATS_EN
    logic [15:0]   stat_count;
    logic [15:0]   stat_stall;
`endif

    shift_pipe_stage #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
`ifdef SHIFT_PIPE_STATS_EN
        ,
        .stat_count(stat_count),
        .stat_stall(stat_stall)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           cyc_q[$];
    int           cyc;
    int           n_cmp;
    int           n_err;
    bit           check_lat;
    bit           rand_ready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: shifts as multiplication / floor division by 2**amt.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [1:0] op,
                                               input logic [AW-1:0] amt);
        int p;
        int v;
        int q;
        p = 2 ** int'(amt);
        case (op)
            2'd0, 2'd2: q = (int'(d) * p) % MOD;
            2'd1:       q = int'(d) / p;
            default: begin
                v = (int'(d) >= MOD / 2) ? int'(d) - MOD : int'(d);
                q = v / p;
                if (v < 0 && q * p != v) q = q - 1;  // floor toward -inf
                q = ((q % MOD) + MOD) % MOD;
            end
        endcase
        return W'(q);
    endfunction

    // ---------------- monitor (samples mid-cycle) ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        int           c;
        if (!rst) begin
            cyc++;
            if (out_valid && out_ready) begin
                check_eq("out_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check_eq("out_data", 32'(out_data), 32'(e));
                    check_eq("out_zero", 32'(out_zero), 32'(e == '0));
                    if (check_lat) check_eq("latency", 32'(cyc - c), 32'd2);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(in_data, in_op, in_amt));
                cyc_q.push_back(cyc);
            end
        end
    end

    // ---------------- random consumer ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] d, input logic [1:0] op, input logic [AW-1:0] amt);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_amt   = amt;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("send_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) begin
            in_data = W'($urandom);     // junk while in_valid=0
            in_op   = 2'($urandom);
            in_amt  = AW'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_zero", 32'(out_zero), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hold_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] held;
        int           acc_n;
        bit           a;
        n_cmp      = 0;
        n_err      = 0;
        cyc        = 0;
        check_lat  = 1'b0;
        rand_ready = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_op      = '0;
        in_amt     = '0;
        out_ready  = 1'b1;
        held       = '0;

        #1;
        check_eq("init_out_valid", 32'(out_valid), 32'd0);
        check_eq("init_out_data", 32'(out_data), 32'd0);
        check_eq("init_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("init_release_in_ready", 32'(in_ready), 32'd1);
        idle(2);

        // Streaming, back-to-back, fixed latency
        check_lat = 1'b1;
        out_ready = 1'b1;
        for (int a8 = 1; a8 <= 8; a8++) send(9'h003, 2'b00, AW'(a8));
        drain();
        check_lat = 1'b0;

        // Directed boundary and arithmetic cases
        send(9'h180, 2'b11, 4'd3);
        send(9'h180, 2'b01, 4'd3);
        send(9'h180, 2'b11, 4'd15);
        send(9'h0FF, 2'b00, 4'd9);
        send(9'h100, 2'b11, 4'd12);
        send(9'h155, 2'b10, 4'd0);
        send(9'h1AB, 2'b01, 4'd9);
        send(9'h0AB, 2'b11, 4'd4);
        drain();
        idle(2);

        // Backpressure: consumer stalls, producer keeps offering
        out_ready = 1'b0;
        acc_n     = 0;
        in_valid  = 1'b1;
        in_data   = W'($urandom);
        in_op     = 2'($urandom);
        in_amt    = AW'($urandom);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a = in_ready;
            if (a) acc_n++;
            @(posedge clk);
            #1;
            if (a) begin
                in_data = W'($urandom);
                in_op   = 2'($urandom);
                in_amt  = AW'($urandom);
            end
            if (k == 1) held = out_data;
        end
        check_eq("bp_accepted", 32'(acc_n), 32'd2);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_out_valid", 32'(out_valid), 32'd1);
        check_eq("bp_out_hold", 32'(out_data), 32'(held));
        out_ready = 1'b1;
        send(in_data, in_op, in_amt);
        send(9'h07F, 2'b01, 4'd2);
        drain();

        // Reset mid-stream with both stages full
        out_ready = 1'b0;
        send(9'h011, 2'b00, 4'd1);
        send(9'h022, 2'b00, 4'd1);
        apply_reset();
        out_ready = 1'b1;
        idle(5);   // any output now would be a stale word

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(W'($urandom), 2'($urandom), AW'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

`ifdef SHIFT_PIPE_STATS_EN
        // 10 deliveries, 3 stall cycles
        apply_reset();
        check_eq("stat_count_rst", 32'(stat_count), 32'd0);
        check_eq("stat_stall_rst", 32'(stat_stall), 32'd0);
        out_ready = 1'b0;
        send(9'h001, 2'b00, 4'd0);
        @(posedge clk);
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send(W'($urandom), 2'($urandom), AW'($urandom));
        drain();
        @(posedge clk);
        #1;
        check_eq("stat_count_10", 32'(stat_count), 32'd10);
        check_eq("stat_stall_3", 32'(stat_stall), 32'd3);

        // Wrap of delivery counter
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) send(W'(i), 2'(i), AW'(i));
        drain();
        @(posedge clk);
        #1;
        check_eq("stat_count_max", 32'(stat_count), 32'd65535);
        send(9'h005, 2'b01, 4'd1);
        drain();
        @(posedge clk);
        #1;
        check_eq("stat_count_wrap", 32'(stat_count), 32'd0);
`endif

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
